// File: rtl/wm_input_pkg.sv
// Shared types and constants for the washer input conditioning block.
// Holds the debounce state encoding, the default debounce length and the counter width.
package wm_input_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] DEB_COUNT_DEF = 16'd50000;

  typedef enum logic [1:0] {
    HI_STABLE = 2'd0,
    HI_CHECK  = 2'd1,
    LO_STABLE = 2'd2,
    LO_CHECK  = 2'd3
  } deb_state_e;

  // Counter increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wm_input_cond_if.sv
// Per-channel result bundle from a debouncer: registered level, fall strobe, abort strobe.
// The debouncer drives it (master); the conditioning top consumes it (slave).
interface wm_input_cond_if;
  logic level;
  logic fall;
  logic abort;

  modport master (output level, output fall, output abort);
  modport slave  (input level, input fall, input abort);
endinterface

// File: rtl/wm_debounce.sv
// One debounced channel: SYNC_STAGES synchronizer, 4-state debounce FSM with saturating counter.
// Latency raw edge -> level/fall: SYNC_STAGES+DEB_COUNT+1 cycles; no backpressure.
module wm_debounce
  import wm_input_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEB_COUNT   = DEB_COUNT_DEF,
  parameter int               SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            raw_n,
  wm_input_cond_if.master ch
);

  // DEB_COUNT of 0 is treated like 1 so the compare below never underflows.
  localparam logic [CNT_W-1:0] DEB_LAST = (DEB_COUNT == '0) ? '0 : DEB_COUNT - 1'b1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  deb_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   fall_q, fall_d;
  logic                   abort_q, abort_d;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_n};
    state_d = state_q;
    cnt_d   = cnt_q;
    fall_d  = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      HI_STABLE: begin
        if (!sync) begin
          state_d = HI_CHECK;
          cnt_d   = '0;
        end
      end
      HI_CHECK: begin
        if (sync) begin
          state_d = HI_STABLE;
          abort_d = 1'b1;
        end else if (cnt_q >= DEB_LAST) begin
          state_d = LO_STABLE;
          fall_d  = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      LO_STABLE: begin
        if (sync) begin
          state_d = LO_CHECK;
          cnt_d   = '0;
        end
      end
      LO_CHECK: begin
        if (!sync) begin
          state_d = LO_STABLE;
          abort_d = 1'b1;
        end else if (cnt_q >= DEB_LAST) begin
          state_d = HI_STABLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = HI_STABLE;
        cnt_d   = '0;
      end
    endcase
    // A CHECK state still reports the level it came from.
    level_d = (state_d == HI_STABLE) || (state_d == HI_CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      state_q <= HI_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      fall_q  <= fall_d;
      abort_q <= abort_d;
    end
  end

  assign ch.level = level_q;
  assign ch.fall  = fall_q;
  assign ch.abort = abort_q;

endmodule

// File: rtl/wm_input_cond.sv
// Conditions the washer's start, water-full and accelerate inputs (sync + debounce); no backpressure.
// Latency raw edge -> output SYNC_STAGES+DEB_COUNT+1 cycles; WM_ACC_TOGGLE_EN makes acc a press-toggle.
module wm_input_cond
  import wm_input_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEB_COUNT   = DEB_COUNT_DEF,
  parameter int               SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start_n,
  input  logic i_water_full_n,
  input  logic i_acc_n,
  output logic o_start_n,
  output logic o_water_full_n,
  output logic o_acc_n,
  output logic o_glitch
);

  wm_input_cond_if start_ch ();
  wm_input_cond_if water_ch ();
  wm_input_cond_if acc_ch ();

  wm_debounce #(.DEB_COUNT(DEB_COUNT), .SYNC_STAGES(SYNC_STAGES)) u_start_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_n (i_start_n),
    .ch    (start_ch)
  );

  wm_debounce #(.DEB_COUNT(DEB_COUNT), .SYNC_STAGES(SYNC_STAGES)) u_water_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_n (i_water_full_n),
    .ch    (water_ch)
  );

  wm_debounce #(.DEB_COUNT(DEB_COUNT), .SYNC_STAGES(SYNC_STAGES)) u_acc_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_n (i_acc_n),
    .ch    (acc_ch)
  );

  // The fall strobe fires once per accepted press, so holding the button cannot repeat it.
  assign o_start_n      = ~start_ch.fall;
  assign o_water_full_n = water_ch.level;
  assign o_glitch       = start_ch.abort | water_ch.abort | acc_ch.abort;

`ifdef WM_ACC_TOGGLE_EN
  logic acc_lat_q, acc_lat_d;

  always_comb begin
    acc_lat_d = acc_lat_q;
    if (acc_ch.fall) begin
      acc_lat_d = ~acc_lat_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_lat_q <= 1'b0;
    end else begin
      acc_lat_q <= acc_lat_d;
    end
  end

  assign o_acc_n = ~acc_lat_q;

  logic unused_bits;
  assign unused_bits = ^{start_ch.level, water_ch.fall, acc_ch.level};
`else
  assign o_acc_n = acc_ch.level;

  logic unused_bits;
  assign unused_bits = ^{start_ch.level, water_ch.fall, acc_ch.fall};
`endif

endmodule

// File: tb/tb_wm_input_cond.sv
// Directed bench for wm_input_cond with DEB_COUNT=4, SYNC_STAGES=2 (expected latency 7 cycles).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_wm_input_cond;

  logic clk;
  logic rst_n;
  logic i_start_n;
  logic i_water_full_n;
  logic i_acc_n;
  logic o_start_n;
  logic o_water_full_n;
  logic o_acc_n;
  logic o_glitch;

  int tests_run;
  int tests_failed;

  localparam int LAT = 7;

  wm_input_cond #(.DEB_COUNT(16'd4), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start_n      (i_start_n),
    .i_water_full_n (i_water_full_n),
    .i_acc_n        (i_acc_n),
    .o_start_n      (o_start_n),
    .o_water_full_n (o_water_full_n),
    .o_acc_n        (o_acc_n),
    .o_glitch       (o_glitch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_start_n = 1'b1;
    i_water_full_n = 1'b1;
    i_acc_n = 1'b1;
    idle(3);
    tests_run++;
    if (o_start_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_start: got %b want 1", o_start_n);
    end
    tests_run++;
    if (o_water_full_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_water: got %b want 1", o_water_full_n);
    end
    tests_run++;
    if (o_acc_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_acc: got %b want 1", o_acc_n);
    end
    tests_run++;
    if (o_glitch !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_glitch: got %b want 0", o_glitch);
    end
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_start_strobe();
    int lows = 0;
    int first_low = -1;
    int glitches = 0;
    i_start_n = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (o_start_n === 1'b0) begin
        lows++;
        if (first_low < 0) first_low = k;
      end
      if (o_glitch === 1'b1) glitches++;
      if (k == 20) i_start_n = 1'b1;
    end
    tests_run++;
    if (first_low !== LAT) begin
      tests_failed++;
      $display("FAIL start_latency: strobe at cycle %0d want %0d", first_low, LAT);
    end
    tests_run++;
    if (lows !== 1) begin
      tests_failed++;
      $display("FAIL start_single: %0d low cycles want 1", lows);
    end
    tests_run++;
    if (glitches !== 0) begin
      tests_failed++;
      $display("FAIL start_no_glitch: %0d glitch pulses want 0", glitches);
    end
  endtask

  task automatic test_water_glitch();
    int glitches = 0;
    int first_glitch = -1;
    int water_lows = 0;
    i_water_full_n = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (o_glitch === 1'b1) begin
        glitches++;
        if (first_glitch < 0) first_glitch = k;
      end
      if (o_water_full_n !== 1'b1) water_lows++;
      if (k == 2) i_water_full_n = 1'b1;
    end
    tests_run++;
    if (glitches !== 1) begin
      tests_failed++;
      $display("FAIL water_glitch_count: %0d pulses want 1", glitches);
    end
    tests_run++;
    if (first_glitch !== 5) begin
      tests_failed++;
      $display("FAIL water_glitch_time: pulse at cycle %0d want 5", first_glitch);
    end
    tests_run++;
    if (water_lows !== 0) begin
      tests_failed++;
      $display("FAIL water_glitch_level: %0d non-high cycles want 0", water_lows);
    end
  endtask

  task automatic test_water_level();
    int fall_at = -1;
    int rise_at = -1;
    int glitches = 0;
    i_water_full_n = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (fall_at < 0 && o_water_full_n === 1'b0) fall_at = k;
      if (fall_at > 0 && rise_at < 0 && k > 10 && o_water_full_n === 1'b1) rise_at = k;
      if (o_glitch === 1'b1) glitches++;
      if (k == 10) i_water_full_n = 1'b1;
    end
    tests_run++;
    if (fall_at !== LAT) begin
      tests_failed++;
      $display("FAIL water_fall: low at cycle %0d want %0d", fall_at, LAT);
    end
    tests_run++;
    if (rise_at !== 10 + LAT) begin
      tests_failed++;
      $display("FAIL water_rise: high at cycle %0d want %0d", rise_at, 10 + LAT);
    end
    tests_run++;
    if (glitches !== 0) begin
      tests_failed++;
      $display("FAIL water_level_glitch: %0d pulses want 0", glitches);
    end
  endtask

  task automatic test_acc();
    logic mid_exp [2];
    logic end_exp [2];
`ifdef WM_ACC_TOGGLE_EN
    mid_exp[0] = 1'b0; end_exp[0] = 1'b0;
    mid_exp[1] = 1'b1; end_exp[1] = 1'b1;
`else
    mid_exp[0] = 1'b0; end_exp[0] = 1'b1;
    mid_exp[1] = 1'b0; end_exp[1] = 1'b1;
`endif
    for (int p = 0; p < 2; p++) begin
      i_acc_n = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (k == 9) begin
          tests_run++;
          if (o_acc_n !== mid_exp[p]) begin
            tests_failed++;
            $display("FAIL acc_press%0d_mid: got %b want %b", p, o_acc_n, mid_exp[p]);
          end
        end
        if (k == 10) i_acc_n = 1'b1;
      end
      tests_run++;
      if (o_acc_n !== end_exp[p]) begin
        tests_failed++;
        $display("FAIL acc_press%0d_end: got %b want %b", p, o_acc_n, end_exp[p]);
      end
    end
  endtask

  task automatic test_reset_mid_check();
    int strobes = 0;
    int glitches = 0;
    i_start_n = 1'b0;
    idle(4);
    rst_n = 1'b0;
    i_start_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({o_start_n, o_water_full_n, o_acc_n, o_glitch} !== 4'b1110) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got %b want 1110",
               {o_start_n, o_water_full_n, o_acc_n, o_glitch});
    end
    idle(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (o_start_n === 1'b0) strobes++;
      if (o_glitch === 1'b1) glitches++;
    end
    tests_run++;
    if (strobes !== 0) begin
      tests_failed++;
      $display("FAIL rst_mid_strobe: %0d strobes want 0", strobes);
    end
    tests_run++;
    if (glitches !== 0) begin
      tests_failed++;
      $display("FAIL rst_mid_glitch: %0d pulses want 0", glitches);
    end
  endtask

  task automatic test_held_through_reset();
    int strobes = 0;
    int first_low = -1;
    rst_n = 1'b0;
    i_start_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (o_start_n === 1'b0) begin
        strobes++;
        if (first_low < 0) first_low = k;
      end
    end
    tests_run++;
    if (strobes !== 1 || first_low !== LAT) begin
      tests_failed++;
      $display("FAIL held_reset_strobe: %0d strobes first at %0d want 1 at %0d",
               strobes, first_low, LAT);
    end
    i_start_n = 1'b1;
    idle(15);
  endtask

  task automatic test_simultaneous();
    int start_at = -1;
    int water_at = -1;
    int glitches = 0;
    i_start_n = 1'b0;
    i_water_full_n = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (start_at < 0 && o_start_n === 1'b0) start_at = k;
      if (water_at < 0 && o_water_full_n === 1'b0) water_at = k;
      if (o_glitch === 1'b1) glitches++;
    end
    tests_run++;
    if (start_at !== LAT || water_at !== LAT) begin
      tests_failed++;
      $display("FAIL simul_change: start at %0d water at %0d want both %0d",
               start_at, water_at, LAT);
    end
    tests_run++;
    if (glitches !== 0) begin
      tests_failed++;
      $display("FAIL simul_glitch: %0d pulses want 0", glitches);
    end
    i_start_n = 1'b1;
    i_water_full_n = 1'b1;
    idle(15);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    i_start_n = 1'b1;
    i_water_full_n = 1'b1;
    i_acc_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_start_strobe();
    test_water_glitch();
    test_water_level();
    test_acc();
    test_reset_mid_check();
    test_held_through_reset();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
